cpu_top: RTL and testbench
==========================

CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk_in  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  run enable; low stalls the FSM in its current state with all registers held.
REQ-005 data_ram_we  output  1  data RAM write strobe.
REQ-006 addr_data_ram  output  16  data RAM byte address.
REQ-007 din_data_ram  output  8  write data to data RAM.
REQ-008 dout_data_ram  input  8  read data from data RAM; one-cycle synchronous-read latency.
REQ-009 inst_ram_we  output  1  instruction RAM write strobe; tied 0.
REQ-010 addr_inst_ram  output  10  instruction word address; always equals PC.
REQ-011 din_inst_ram  output  32  instruction RAM write data; tied 0.
REQ-012 dout_inst_ram  input  32  instruction word; one-cycle synchronous-read latency.
REQ-013 finish  output  1  high while the CPU is in HALT.

Function
REQ-014 State: PC (10 bits), IR (32 bits), register file R0..R15 (8 bits each).
REQ-015 Instruction format: [31:24] opcode, [23:20] rd, [19:16] rs, [15:0] imm.
REQ-016 Opcodes:
- 00 NOP.
- 01 LDI: rd=imm[7:0].
- 02 LD: rd=mem[imm].
- 03 ST: mem[imm]=rd.
- 04 ADD: rd=rd+rs.
- 05 SUB: rd=rd-rs.
- 06 AND, 07 OR: rd=rd op rs.
- 08 MOV: rd=rs.
- 09 INC, 0A DEC: rd=rd±1.
- 0B JMP: PC=imm[9:0].
- 0C JZ: PC=imm[9:0] if rd==0.
- 0D JNZ: PC=imm[9:0] if rd!=0.
- FF HALT.
- All other opcodes execute as NOP.
REQ-017 All arithmetic is modulo 256; no flags are kept.
REQ-018 PC increments by 1 after each non-taken instruction and wraps from 1023 to 0.
REQ-019 FSM states: IDLE, FETCH, LATCH, EXEC, LOAD, HALT.
- IDLE->FETCH when enable=1.
- FETCH->LATCH.
- LATCH: IR<=dout_inst_ram; ->EXEC.
- EXEC: LD goes ->LOAD, HALT goes ->HALT, all others ->FETCH.
- LOAD: rd<=dout_data_ram; ->FETCH.
- HALT is terminal until reset.
REQ-020 Latency: 3 cycles per instruction (FETCH, LATCH, EXEC); LD takes 4 cycles.
REQ-021 ST: in EXEC, data_ram_we=1 for exactly one cycle, addr_data_ram=imm, din_data_ram=R[rd].
REQ-022 LD: addr_data_ram=imm during EXEC and LOAD; data_ram_we=0.
REQ-023 Outside ST/LD, addr_data_ram=0, din_data_ram=0, data_ram_we=0.
REQ-024 enable=0 in any state freezes state, PC, IR and registers; data_ram_we is forced to 0 while stalled.
REQ-025 finish is registered, asserts on entry to HALT and stays high until reset.
REQ-026 Reads of the register file are combinational; writes occur on the EXEC or LOAD edge.

Reset
REQ-027 reset=1 at a rising edge: state=IDLE, PC=0, IR=0, R0..R15=0, finish=0, data_ram_we=0, addr_data_ram=0, din_data_ram=0.
REQ-028 Reset has priority over enable and aborts any instruction in flight, including a store in EXEC (no write issued).

Structure
REQ-029 Opcode and FSM state encodings are constants in a shared package cpu_pkg.
REQ-030 The register file is one natural sub-module, cpu_regfile: 16x8, one write port, two combinational read ports.

Verification
REQ-031 Program "LDI R1,5; LDI R2,3; ADD R1,R2; ST R1,[0x0010]; HALT" -> one write of 0x08 to address 0x0010; finish=1 after 15 enabled cycles.
REQ-032 LDI R1,0xFF; INC R1; ST R1,[0] -> writes 0x00 (wrap).
REQ-033 LD R3,[0x1234] with dout_data_ram=0x5A, then ST R3,[1] -> addr_data_ram=0x1234 for 2 cycles, then 0x5A written to address 1.
REQ-034 LDI R0,2; DEC R0; JNZ R0,1; HALT -> loop executes twice and finish asserts; JZ on R0=0 is taken.
REQ-035 Deassert enable for 5 cycles mid-program -> no state change and no write; the result is identical to an uninterrupted run.
REQ-036 Assert reset while finish=1 -> finish=0, PC=0, state IDLE on the next cycle; the program reruns when enable=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit accumulator-free CPU: widths, opcodes, FSM states
// and the instruction word layout.
package cpu_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned PC_W    = 10;
    localparam int unsigned INST_W  = 32;
    localparam int unsigned REG_N   = 16;
    localparam int unsigned REG_AW  = 4;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_LDI  = 8'h01,
        OP_LD   = 8'h02,
        OP_ST   = 8'h03,
        OP_ADD  = 8'h04,
        OP_SUB  = 8'h05,
        OP_AND  = 8'h06,
        OP_OR   = 8'h07,
        OP_MOV  = 8'h08,
        OP_INC  = 8'h09,
        OP_DEC  = 8'h0A,
        OP_JMP  = 8'h0B,
        OP_JZ   = 8'h0C,
        OP_JNZ  = 8'h0D,
        OP_HALT = 8'hFF
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC  = 3'd3,
        S_LOAD  = 3'd4,
        S_HALT  = 3'd5
    } state_e;

    // Opcode is kept as raw bits so undefined encodings can fall through to NOP.
    typedef struct packed {
        logic [7:0]        opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [ADDR_W-1:0] imm;
    } inst_t;

endpackage

// File: rtl/cpu_regfile.sv
// 16 x 8 register file: one synchronous write port, two combinational read ports.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [REG_N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu_top.sv
// Multi-cycle 8-bit CPU: FETCH/LATCH/EXEC per instruction, extra LOAD cycle for LD,
// synchronous-read instruction and data RAMs outside the core.
module cpu_top
    import cpu_pkg::*;
(
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    output logic              data_ram_we,
    output logic [ADDR_W-1:0] addr_data_ram,
    output logic [DATA_W-1:0] din_data_ram,
    input  logic [DATA_W-1:0] dout_data_ram,
    output logic              inst_ram_we,
    output logic [PC_W-1:0]   addr_inst_ram,
    output logic [INST_W-1:0] din_inst_ram,
    input  logic [INST_W-1:0] dout_inst_ram,
    output logic              finish
);

    state_e            state;
    logic [PC_W-1:0]   pc;
    inst_t             ir;
    inst_t             fetched;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              finish_q;

    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [REG_AW-1:0] rf_raddr_a;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic              taken;

    assign fetched = inst_t'(dout_inst_ram);

    // Port A looks at the incoming word in LATCH so a store's data can be registered early.
    assign rf_raddr_a = (state == S_LATCH) ? fetched.rd : ir.rd;

    cpu_regfile u_regfile (
        .clk     (clk_in),
        .reset   (reset),
        .we      (rf_we & enable),
        .waddr   (ir.rd),
        .wdata   (rf_wdata),
        .raddr_a (rf_raddr_a),
        .rdata_a (rd_val),
        .raddr_b (ir.rs),
        .rdata_b (rs_val)
    );

    // Execute-stage datapath: register writeback value and branch decision.
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = '0;
        taken    = 1'b0;
        if (state == S_EXEC) begin
            case (ir.opcode)
                OP_LDI: begin rf_we = 1'b1; rf_wdata = ir.imm[DATA_W-1:0]; end
                OP_ADD: begin rf_we = 1'b1; rf_wdata = rd_val + rs_val; end
                OP_SUB: begin rf_we = 1'b1; rf_wdata = rd_val - rs_val; end
                OP_AND: begin rf_we = 1'b1; rf_wdata = rd_val & rs_val; end
                OP_OR:  begin rf_we = 1'b1; rf_wdata = rd_val | rs_val; end
                OP_MOV: begin rf_we = 1'b1; rf_wdata = rs_val; end
                OP_INC: begin rf_we = 1'b1; rf_wdata = rd_val + DATA_W'(1); end
                OP_DEC: begin rf_we = 1'b1; rf_wdata = rd_val - DATA_W'(1); end
                OP_JMP: taken = 1'b1;
                OP_JZ:  taken = (rd_val == '0);
                OP_JNZ: taken = (rd_val != '0);
                default: ;
            endcase
        end else if (state == S_LOAD) begin
            rf_we    = 1'b1;
            rf_wdata = dout_data_ram;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            finish_q <= 1'b0;
        end else if (enable) begin
            case (state)
                S_IDLE:  state <= S_FETCH;
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    ir    <= fetched;
                    state <= S_EXEC;
                    // Memory-side outputs are set up here so they are valid throughout EXEC.
                    if (fetched.opcode == OP_ST) begin
                        we_q   <= 1'b1;
                        addr_q <= fetched.imm;
                        din_q  <= rd_val;
                    end else if (fetched.opcode == OP_LD) begin
                        addr_q <= fetched.imm;
                    end
                end
                S_EXEC: begin
                    we_q  <= 1'b0;
                    din_q <= '0;
                    if (ir.opcode == OP_HALT) begin
                        state    <= S_HALT;
                        finish_q <= 1'b1;
                    end else begin
                        pc <= taken ? ir.imm[PC_W-1:0] : pc + PC_W'(1);
                        if (ir.opcode == OP_LD) begin
                            state  <= S_LOAD;
                            addr_q <= ir.imm;
                        end else begin
                            state  <= S_FETCH;
                            addr_q <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    addr_q <= '0;
                    state  <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // The strobe is suppressed while stalled or in reset so a held store never fires early.
    assign data_ram_we   = we_q & enable & ~reset;
    assign addr_data_ram = addr_q;
    assign din_data_ram  = din_q;
    assign finish        = finish_q;

    assign inst_ram_we   = 1'b0;
    assign din_inst_ram  = '0;
    assign addr_inst_ram = pc;

endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: directed programs plus random programs with random stalls,
// each checked against an instruction-level interpreter of the ISA.
module tb_cpu_top;

    logic        clk_in;
    logic        reset;
    logic        enable;
    logic        data_ram_we;
    logic [15:0] addr_data_ram;
    logic [7:0]  din_data_ram;
    logic [7:0]  dout_data_ram;
    logic        inst_ram_we;
    logic [9:0]  addr_inst_ram;
    logic [31:0] din_inst_ram;
    logic [31:0] dout_inst_ram;
    logic        finish;

    cpu_top dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .enable        (enable),
        .data_ram_we   (data_ram_we),
        .addr_data_ram (addr_data_ram),
        .din_data_ram  (din_data_ram),
        .dout_data_ram (dout_data_ram),
        .inst_ram_we   (inst_ram_we),
        .addr_inst_ram (addr_inst_ram),
        .din_inst_ram  (din_inst_ram),
        .dout_inst_ram (dout_inst_ram),
        .finish        (finish)
    );

    always #5 clk_in = ~clk_in;

    logic [31:0] imem [1024];
    logic [7:0]  dmem [int];
    logic [23:0] wlog [$];
    logic [23:0] exp_log [$];
    logic [31:0] prog [$];
    int          n1234;
    int          vecs;
    int          errs;
    int          last_cyc;

    // Synchronous-read memories and a log of every write strobe the DUT issues.
    always @(posedge clk_in) begin
        dout_inst_ram <= imem[addr_inst_ram];
        dout_data_ram <= dmem.exists(int'(addr_data_ram)) ? dmem[int'(addr_data_ram)] : 8'h00;
        if (data_ram_we) begin
            dmem[int'(addr_data_ram)] = din_data_ram;
            wlog.push_back({addr_data_ram, din_data_ram});
        end
        if (addr_data_ram == 16'h1234) n1234++;
    end

    function automatic logic [31:0] enc(int op, int rd, int rs, int imm);
        return {8'(op), 4'(rd), 4'(rs), 16'(imm)};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_imem();
        for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
        for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
    endtask

    // ISA interpreter: expected store sequence and enabled cycles after leaving IDLE.
    task automatic model_run(output int cyc);
        int r [16];
        logic [7:0] mm [int];
        int pc, nxt, op, rd, rs, imm;
        logic [31:0] w;
        mm = dmem;
        for (int i = 0; i < 16; i++) r[i] = 0;
        pc = 0;
        cyc = 0;
        exp_log.delete();
        for (int step = 0; step < 4000; step++) begin
            w   = imem[pc];
            op  = int'(w[31:24]);
            rd  = int'(w[23:20]);
            rs  = int'(w[19:16]);
            imm = int'(w[15:0]);
            cyc += 3;
            nxt = (pc + 1) % 1024;
            if (op == 255) break;
            case (op)
                1:  r[rd] = imm % 256;
                2:  begin r[rd] = mm.exists(imm) ? int'(mm[imm]) : 0; cyc += 1; end
                3:  begin mm[imm] = 8'(r[rd]); exp_log.push_back({16'(imm), 8'(r[rd])}); end
                4:  r[rd] = (r[rd] + r[rs]) % 256;
                5:  r[rd] = (r[rd] - r[rs] + 256) % 256;
                6:  r[rd] = r[rd] & r[rs];
                7:  r[rd] = r[rd] | r[rs];
                8:  r[rd] = r[rs];
                9:  r[rd] = (r[rd] + 1) % 256;
                10: r[rd] = (r[rd] + 255) % 256;
                11: nxt = imm % 1024;
                12: if (r[rd] == 0) nxt = imm % 1024;
                13: if (r[rd] != 0) nxt = imm % 1024;
                default: ;
            endcase
            pc = nxt;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        wlog.delete();
        n1234 = 0;
    endtask

    // Runs the loaded program to HALT and compares against the interpreter.
    task automatic run_prog(string tag, bit stalls);
        int exp_cyc, cyc, n;
        model_run(exp_cyc);
        do_reset();
        enable = 1'b1;
        @(negedge clk_in);
        cyc = 0;
        while (finish !== 1'b1 && cyc < exp_cyc + 50) begin
            if (stalls && $urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk_in);
            end
            enable = 1'b1;
            @(negedge clk_in);
            cyc++;
        end
        enable   = 1'b0;
        last_cyc = cyc;
        chk({tag, " finish"}, 32'(finish), 32'd1);
        chk({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, " nwrites"}, 32'(wlog.size()), 32'(exp_log.size()));
        n = (wlog.size() < exp_log.size()) ? wlog.size() : exp_log.size();
        for (int i = 0; i < n; i++) chk({tag, " write"}, 32'(wlog[i]), 32'(exp_log[i]));
    endtask

    initial begin
        int n, tgt, op;
        clk_in = 1'b0;
        reset  = 1'b1;
        enable = 1'b0;
        vecs   = 0;
        errs   = 0;
        n1234  = 0;
        prog.delete();
        load_imem();

        // Reset state
        do_reset();
        chk("rst finish", 32'(finish), 32'd0);
        chk("rst we", 32'(data_ram_we), 32'd0);
        chk("rst addr", 32'(addr_data_ram), 32'd0);
        chk("rst din", 32'(din_data_ram), 32'd0);
        chk("rst pc", 32'(addr_inst_ram), 32'd0);
        chk("rst iwe", 32'(inst_ram_we), 32'd0);
        chk("rst idin", din_inst_ram, 32'd0);

        // LDI/ADD/ST then HALT
        prog = '{enc(1,1,0,5), enc(1,2,0,3), enc(4,1,2,0), enc(3,1,0,16'h0010), enc(255,0,0,0)};
        load_imem();
        run_prog("add", 1'b0);
        chk("add cycles15", 32'(last_cyc), 32'd15);
        chk("add data", 32'(wlog.size() > 0 ? wlog[0] : 24'hx), 32'h001008);

        // Reset while halted, then rerun
        reset = 1'b1;
        @(negedge clk_in);
        chk("rehalt finish", 32'(finish), 32'd0);
        chk("rehalt pc", 32'(addr_inst_ram), 32'd0);
        reset = 1'b0;
        run_prog("rerun", 1'b0);

        // Increment wraps to zero
        prog = '{enc(1,1,0,8'hFF), enc(9,1,0,0), enc(3,1,0,0), enc(255,0,0,0)};
        load_imem();
        run_prog("wrap", 1'b0);
        chk("wrap data", 32'(wlog.size() > 0 ? wlog[0] : 24'hx), 32'h000000);

        // Load holds its address for EXEC and LOAD
        dmem[32'h1234] = 8'h5A;
        prog = '{enc(2,3,0,16'h1234), enc(3,3,0,1), enc(255,0,0,0)};
        load_imem();
        run_prog("ld", 1'b0);
        chk("ld addr cycles", 32'(n1234), 32'd2);
        chk("ld data", 32'(wlog.size() > 0 ? wlog[0] : 24'hx), 32'h00015A);

        // Counted loop with JNZ, then taken JZ skipping a store
        prog = '{enc(1,0,0,2), enc(10,0,0,0), enc(13,0,0,1), enc(12,0,0,5),
                 enc(3,0,0,16'h0099), enc(3,0,0,16'h0020), enc(255,0,0,0)};
        load_imem();
        run_prog("loop", 1'b0);
        chk("loop cycles", 32'(last_cyc), 32'd24);
        chk("loop data", 32'(wlog.size() > 0 ? wlog[0] : 24'hx), 32'h002000);

        // Stall for 5 cycles with a store sitting in EXEC
        prog = '{enc(1,1,0,7), enc(3,1,0,5), enc(255,0,0,0)};
        load_imem();
        do_reset();
        enable = 1'b1;
        repeat (6) @(negedge clk_in);
        chk("st we", 32'(data_ram_we), 32'd1);
        chk("st addr", 32'(addr_data_ram), 32'd5);
        chk("st din", 32'(din_data_ram), 32'd7);
        enable = 1'b0;
        #1;
        chk("stall we", 32'(data_ram_we), 32'd0);
        repeat (5) @(negedge clk_in);
        chk("stall nwrites", 32'(wlog.size()), 32'd0);
        chk("stall pc", 32'(addr_inst_ram), 32'd1);
        chk("stall addr", 32'(addr_data_ram), 32'd5);
        enable = 1'b1;
        @(negedge clk_in);
        chk("resume nwrites", 32'(wlog.size()), 32'd1);
        chk("resume data", 32'(wlog.size() > 0 ? wlog[0] : 24'hx), 32'h000507);
        chk("resume we", 32'(data_ram_we), 32'd0);
        repeat (3) @(negedge clk_in);
        chk("resume finish", 32'(finish), 32'd1);

        // Reset aborts a store in EXEC
        do_reset();
        enable = 1'b1;
        repeat (6) @(negedge clk_in);
        reset = 1'b1;
        #1;
        chk("abort we", 32'(data_ram_we), 32'd0);
        @(negedge clk_in);
        chk("abort nwrites", 32'(wlog.size()), 32'd0);
        chk("abort addr", 32'(addr_data_ram), 32'd0);
        chk("abort din", 32'(din_data_ram), 32'd0);
        chk("abort pc", 32'(addr_inst_ram), 32'd0);
        reset  = 1'b0;
        enable = 1'b0;

        // Random straight-line programs with forward branches, then dump all registers
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(8, 14);
            prog.delete();
            for (int i = 0; i < n; i++) begin
                op = $urandom_range(0, 14);
                tgt = $urandom_range(i + 1, (i + 3 < n) ? i + 3 : n);
                case (op)
                    0:  prog.push_back(enc(8'h5C, $urandom_range(0,15), 0, 0));
                    2:  begin
                            tgt = $urandom_range(0, 16'hFFFF);
                            dmem[tgt] = 8'($urandom_range(0, 255));
                            prog.push_back(enc(2, $urandom_range(0,15), 0, tgt));
                        end
                    11, 12, 13: prog.push_back(enc(op, $urandom_range(0,15), 0, tgt));
                    14: prog.push_back(enc(1, $urandom_range(0,15), 0, $urandom_range(0,16'hFFFF)));
                    default: prog.push_back(enc(op, $urandom_range(0,15), $urandom_range(0,15),
                                                $urandom_range(0, 16'hFFFF)));
                endcase
            end
            for (int i = 0; i < 16; i++) prog.push_back(enc(3, i, 0, 16'h0100 + i));
            prog.push_back(enc(255, 0, 0, 0));
            load_imem();
            run_prog("rand", 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
